// File: rtl/riscv_core_hazard_scoreboard_pkg.sv
// Shared hazard-unit definitions: forward-mux encodings, load result-source code
// and the forward-select priority helper.
package riscv_core_hazard_scoreboard_pkg;

  localparam logic [1:0] FWD_RF         = 2'b00;
  localparam logic [1:0] FWD_WB         = 2'b01;
  localparam logic [1:0] FWD_MEM        = 2'b10;
  localparam logic [1:0] RESULTSRC_LOAD = 2'b01;

  // MEM beats WB; x0 and registers still owned by a long unit read the RF.
  function automatic logic [1:0] fwd_sel(input logic rs_nz, input logic rs_busy,
                                         input logic mem_hit, input logic wb_hit);
    logic [1:0] sel;
    sel = FWD_RF;
    if (rs_nz && !rs_busy && mem_hit) begin
      sel = FWD_MEM;
    end else if (rs_nz && !rs_busy && wb_hit) begin
      sel = FWD_WB;
    end else begin
      sel = FWD_RF;
    end
    return sel;
  endfunction

endpackage

// File: rtl/riscv_core_scoreboard_reg.sv
// Busy-register vector and in-flight counter for long-latency writebacks,
// with a sticky flag for done-underflow and issue-overflow.
module riscv_core_scoreboard_reg
  import riscv_core_hazard_scoreboard_pkg::*;
#(
  parameter int NUM_REGS        = 32,
  parameter int MAX_OUTSTANDING = 4,
  parameter int RW              = 5,
  parameter int OW              = 3
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                issue,
  input  logic [RW-1:0]       issue_rd,
  input  logic                done,
  input  logic [RW-1:0]       done_rd,
  output logic [NUM_REGS-1:0] busy,
  output logic [OW-1:0]       outstanding,
  output logic                error
);

  localparam logic [OW-1:0] CNT_ZERO = OW'(0);
  localparam logic [OW-1:0] CNT_ONE  = OW'(1);
  localparam logic [OW-1:0] CNT_MAX  = OW'(MAX_OUTSTANDING);
  localparam logic [RW-1:0] REG_ZERO = RW'(0);

  logic [NUM_REGS-1:0] busy_r;
  logic [NUM_REGS-1:0] busy_nxt_s;
  logic [OW-1:0]       cnt_r;
  logic [OW-1:0]       cnt_nxt_s;
  logic                err_r;
  logic                err_evt_s;

  // Next busy vector and count; a protocol error freezes both for that cycle.
  always_comb begin
    busy_nxt_s = busy_r;
    cnt_nxt_s  = cnt_r;
    err_evt_s  = (done && (cnt_r == CNT_ZERO)) ||
                 (issue && !done && (cnt_r == CNT_MAX));
    if (err_evt_s) begin
      busy_nxt_s = busy_r;
      cnt_nxt_s  = cnt_r;
    end else begin
      // clear first so a same-register set in this cycle wins
      if (done) begin
        busy_nxt_s[done_rd] = 1'b0;
      end else begin
        busy_nxt_s = busy_r;
      end
      if (issue && (issue_rd != REG_ZERO)) begin
        busy_nxt_s[issue_rd] = 1'b1;
      end else begin
        busy_nxt_s[0] = 1'b0;
      end
      case ({issue, done})
        2'b10:   cnt_nxt_s = cnt_r + CNT_ONE;
        2'b01:   cnt_nxt_s = cnt_r - CNT_ONE;
        default: cnt_nxt_s = cnt_r;
      endcase
    end
    busy_nxt_s[0] = 1'b0;
  end

  // Scoreboard state and sticky error flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy_r <= {NUM_REGS{1'b0}};
      cnt_r  <= CNT_ZERO;
      err_r  <= 1'b0;
    end else begin
      busy_r <= busy_nxt_s;
      cnt_r  <= cnt_nxt_s;
      err_r  <= err_r | err_evt_s;
    end
  end

  assign busy        = busy_r;
  assign outstanding = cnt_r;
  assign error       = err_r;

endmodule

// File: rtl/riscv_core_hazard_scoreboard.sv
// Hazard unit for the 5-stage core: forwarding, stall/flush matrix, long-latency
// register scoreboard and a saturating ID-stall cycle counter.
module riscv_core_hazard_scoreboard
  import riscv_core_hazard_scoreboard_pkg::*;
#(
  parameter  int NUM_REGS        = 32,
  parameter  int MAX_OUTSTANDING = 4,
  parameter  int CNT_W           = 16,
  localparam int RW              = $clog2(NUM_REGS),
  localparam int OW              = $clog2(MAX_OUTSTANDING + 1)
) (
  input  logic                i_clk,
  input  logic                i_rst_n,
  input  logic [RW-1:0]       i_hsb_rs1_id,
  input  logic [RW-1:0]       i_hsb_rs2_id,
  input  logic [RW-1:0]       i_hsb_rd_id,
  input  logic                i_hsb_long_id,
  input  logic [RW-1:0]       i_hsb_rs1_ex,
  input  logic [RW-1:0]       i_hsb_rs2_ex,
  input  logic [RW-1:0]       i_hsb_rd_ex,
  input  logic [1:0]          i_hsb_resultsrc_ex,
  input  logic                i_hsb_long_issue_ex,
  input  logic [RW-1:0]       i_hsb_rd_mem,
  input  logic [RW-1:0]       i_hsb_rd_wb,
  input  logic                i_hsb_regwrite_mem,
  input  logic                i_hsb_regwrite_wb,
  input  logic                i_hsb_long_done,
  input  logic [RW-1:0]       i_hsb_long_done_rd,
  input  logic                i_hsb_pcsrc_ex,
  input  logic                i_hsb_icache_stall,
  input  logic                i_hsb_dcache_stall,
  input  logic                i_hsb_csr_flush_id,
  input  logic                i_hsb_csr_flush_ex,
  input  logic                i_hsb_csr_flush_mem,
  input  logic                i_hsb_csr_flush_wb,
  input  logic                i_hsb_cnt_clr,
  output logic [1:0]          o_hsb_forwarda_ex,
  output logic [1:0]          o_hsb_forwardb_ex,
  output logic                o_hsb_stall_if,
  output logic                o_hsb_stall_id,
  output logic                o_hsb_stall_ex,
  output logic                o_hsb_stall_mem,
  output logic                o_hsb_stall_wb,
  output logic                o_hsb_flush_id,
  output logic                o_hsb_flush_ex,
  output logic                o_hsb_flush_mem,
  output logic                o_hsb_flush_wb,
  output logic [NUM_REGS-1:0] o_hsb_busy,
  output logic [OW-1:0]       o_hsb_outstanding,
  output logic [CNT_W-1:0]    o_hsb_stall_cnt,
  output logic                o_hsb_error
);

  localparam logic [RW-1:0]    REG_ZERO = RW'(0);
  localparam logic [OW:0]      CAP_LIM  = (OW + 1)'(MAX_OUTSTANDING);
  localparam logic [OW-1:0]    CNT_MAX  = OW'(MAX_OUTSTANDING);
  localparam logic [CNT_W-1:0] SC_ZERO  = CNT_W'(0);
  localparam logic [CNT_W-1:0] SC_ONE   = CNT_W'(1);
  localparam logic [CNT_W-1:0] SC_SAT   = {CNT_W{1'b1}};

  logic [NUM_REGS-1:0] busy_s;
  logic [OW-1:0]       outstanding_s;
  logic                lw_s, sb_raw_s, sb_waw_s, cap_s, m_s, hz_s;
  logic                stall_ex_s, stall_id_s, issue_s;
  logic [OW:0]         inflight_s;
  logic [CNT_W-1:0]    stall_cnt_r;

  assign o_hsb_forwarda_ex = fwd_sel(i_hsb_rs1_ex != REG_ZERO, busy_s[i_hsb_rs1_ex],
                                     i_hsb_regwrite_mem && (i_hsb_rd_mem == i_hsb_rs1_ex),
                                     i_hsb_regwrite_wb && (i_hsb_rd_wb == i_hsb_rs1_ex));
  assign o_hsb_forwardb_ex = fwd_sel(i_hsb_rs2_ex != REG_ZERO, busy_s[i_hsb_rs2_ex],
                                     i_hsb_regwrite_mem && (i_hsb_rd_mem == i_hsb_rs2_ex),
                                     i_hsb_regwrite_wb && (i_hsb_rd_wb == i_hsb_rs2_ex));

  // Hazard terms; busy is the registered vector, so a clearing bit still blocks ID.
  always_comb begin
    lw_s       = (i_hsb_resultsrc_ex == RESULTSRC_LOAD) && (i_hsb_rd_ex != REG_ZERO) &&
                 ((i_hsb_rd_ex == i_hsb_rs1_id) || (i_hsb_rd_ex == i_hsb_rs2_id));
    sb_raw_s   = busy_s[i_hsb_rs1_id] || busy_s[i_hsb_rs2_id];
    sb_waw_s   = busy_s[i_hsb_rd_id] && (i_hsb_rd_id != REG_ZERO);
    inflight_s = {1'b0, outstanding_s} + {{OW{1'b0}}, i_hsb_long_issue_ex};
    cap_s      = i_hsb_long_id && (inflight_s >= CAP_LIM);
    m_s        = (outstanding_s == CNT_MAX) && i_hsb_long_issue_ex;
    hz_s       = lw_s | sb_raw_s | sb_waw_s | cap_s;
  end

  // Stall/flush matrix and the scoreboard issue qualifier.
  always_comb begin
    stall_ex_s      = m_s | i_hsb_dcache_stall;
    stall_id_s      = hz_s | m_s | i_hsb_dcache_stall;
    o_hsb_stall_if  = stall_id_s | i_hsb_icache_stall;
    o_hsb_stall_id  = stall_id_s;
    o_hsb_stall_ex  = stall_ex_s;
    o_hsb_stall_mem = i_hsb_dcache_stall;
    o_hsb_stall_wb  = 1'b0;
    o_hsb_flush_id  = i_hsb_pcsrc_ex | i_hsb_csr_flush_id;
    o_hsb_flush_ex  = (hz_s & ~stall_ex_s) | i_hsb_pcsrc_ex | i_hsb_csr_flush_ex;
    o_hsb_flush_mem = i_hsb_csr_flush_mem | m_s;
    o_hsb_flush_wb  = i_hsb_csr_flush_wb;
    issue_s         = i_hsb_long_issue_ex && !stall_ex_s && !i_hsb_csr_flush_mem;
  end

  riscv_core_scoreboard_reg #(
    .NUM_REGS        (NUM_REGS),
    .MAX_OUTSTANDING (MAX_OUTSTANDING),
    .RW              (RW),
    .OW              (OW)
  ) u_sb (
    .clk         (i_clk),
    .rst_n       (i_rst_n),
    .issue       (issue_s),
    .issue_rd    (i_hsb_rd_ex),
    .done        (i_hsb_long_done),
    .done_rd     (i_hsb_long_done_rd),
    .busy        (busy_s),
    .outstanding (outstanding_s),
    .error       (o_hsb_error)
  );

  // Saturating count of ID-stall cycles; clear has priority.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      stall_cnt_r <= SC_ZERO;
    end else if (i_hsb_cnt_clr) begin
      stall_cnt_r <= SC_ZERO;
    end else if (stall_id_s && (stall_cnt_r != SC_SAT)) begin
      stall_cnt_r <= stall_cnt_r + SC_ONE;
    end else begin
      stall_cnt_r <= stall_cnt_r;
    end
  end

  assign o_hsb_busy        = busy_s;
  assign o_hsb_outstanding = outstanding_s;
  assign o_hsb_stall_cnt   = stall_cnt_r;

endmodule

// File: tb/tb_riscv_core_hazard_scoreboard.sv
// Directed bench: expected values are queued when stimulus is driven and popped
// when the corresponding DUT output is sampled.
module tb_riscv_core_hazard_scoreboard;

  localparam int NR = 32;
  localparam int MO = 2;
  localparam int CW = 4;
  localparam int RW = 5;
  localparam int OW = 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst_n;
  logic [RW-1:0] rs1_id, rs2_id, rd_id, rs1_ex, rs2_ex, rd_ex, rd_mem, rd_wb, done_rd;
  logic          long_id, long_issue_ex, regwrite_mem, regwrite_wb, long_done;
  logic [1:0]    resultsrc_ex;
  logic          pcsrc_ex, icache_stall, dcache_stall;
  logic          csr_flush_id, csr_flush_ex, csr_flush_mem, csr_flush_wb, cnt_clr;
  logic [1:0]    fwda, fwdb;
  logic          stall_if, stall_id, stall_ex, stall_mem, stall_wb;
  logic          flush_id, flush_ex, flush_mem, flush_wb;
  logic [NR-1:0] busy;
  logic [OW-1:0] outstanding;
  logic [CW-1:0] stall_cnt;
  logic          error;

  riscv_core_hazard_scoreboard #(.NUM_REGS(NR), .MAX_OUTSTANDING(MO), .CNT_W(CW)) dut (
    .i_clk(clk), .i_rst_n(rst_n),
    .i_hsb_rs1_id(rs1_id), .i_hsb_rs2_id(rs2_id), .i_hsb_rd_id(rd_id), .i_hsb_long_id(long_id),
    .i_hsb_rs1_ex(rs1_ex), .i_hsb_rs2_ex(rs2_ex), .i_hsb_rd_ex(rd_ex),
    .i_hsb_resultsrc_ex(resultsrc_ex), .i_hsb_long_issue_ex(long_issue_ex),
    .i_hsb_rd_mem(rd_mem), .i_hsb_rd_wb(rd_wb),
    .i_hsb_regwrite_mem(regwrite_mem), .i_hsb_regwrite_wb(regwrite_wb),
    .i_hsb_long_done(long_done), .i_hsb_long_done_rd(done_rd),
    .i_hsb_pcsrc_ex(pcsrc_ex), .i_hsb_icache_stall(icache_stall), .i_hsb_dcache_stall(dcache_stall),
    .i_hsb_csr_flush_id(csr_flush_id), .i_hsb_csr_flush_ex(csr_flush_ex),
    .i_hsb_csr_flush_mem(csr_flush_mem), .i_hsb_csr_flush_wb(csr_flush_wb),
    .i_hsb_cnt_clr(cnt_clr),
    .o_hsb_forwarda_ex(fwda), .o_hsb_forwardb_ex(fwdb),
    .o_hsb_stall_if(stall_if), .o_hsb_stall_id(stall_id), .o_hsb_stall_ex(stall_ex),
    .o_hsb_stall_mem(stall_mem), .o_hsb_stall_wb(stall_wb),
    .o_hsb_flush_id(flush_id), .o_hsb_flush_ex(flush_ex),
    .o_hsb_flush_mem(flush_mem), .o_hsb_flush_wb(flush_wb),
    .o_hsb_busy(busy), .o_hsb_outstanding(outstanding),
    .o_hsb_stall_cnt(stall_cnt), .o_hsb_error(error)
  );

  int          tests_run    = 0;
  int          tests_failed = 0;
  logic [31:0] exp_q[$];

  task automatic push(input logic [31:0] v);
    exp_q.push_back(v);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs);
    logic [31:0] e;
    tests_run++;
    if (exp_q.size() == 0) begin
      tests_failed++;
      $error("FAIL %s: observed %0h but no expected value queued", tag, obs);
    end else begin
      e = exp_q.pop_front();
      assert (obs === e) else begin
        tests_failed++;
        $error("FAIL %s: observed %0h expected %0h", tag, obs, e);
      end
    end
  endtask

  task automatic idle();
    rs1_id = 5'd0; rs2_id = 5'd0; rd_id = 5'd0; long_id = 1'b0;
    rs1_ex = 5'd0; rs2_ex = 5'd0; rd_ex = 5'd0; resultsrc_ex = 2'b00; long_issue_ex = 1'b0;
    rd_mem = 5'd0; rd_wb = 5'd0; regwrite_mem = 1'b0; regwrite_wb = 1'b0;
    long_done = 1'b0; done_rd = 5'd0; pcsrc_ex = 1'b0; icache_stall = 1'b0; dcache_stall = 1'b0;
    csr_flush_id = 1'b0; csr_flush_ex = 1'b0; csr_flush_mem = 1'b0; csr_flush_wb = 1'b0;
    cnt_clr = 1'b0;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    // reset state
    idle(); rst_n = 1'b0;
    push(32'd0); push(32'd0); push(32'd0); push(32'd0);
    #2;
    chk("rst_busy", busy); chk("rst_outstanding", 32'(outstanding));
    chk("rst_stall_cnt", 32'(stall_cnt)); chk("rst_error", 32'(error));
    rst_n = 1'b1;
    step();

    // forwarding priority
    rs1_ex = 5'd5; rs2_ex = 5'd5; rd_mem = 5'd5; rd_wb = 5'd5;
    regwrite_mem = 1'b1; regwrite_wb = 1'b1;
    push(32'h2); push(32'h2);
    #1; chk("fwda_mem_over_wb", 32'(fwda)); chk("fwdb_mem_over_wb", 32'(fwdb));
    regwrite_mem = 1'b0; push(32'h1);
    #1; chk("fwda_wb_only", 32'(fwda));
    rs1_ex = 5'd0; regwrite_mem = 1'b1; push(32'h0);
    #1; chk("fwda_x0", 32'(fwda));

    // load-use hazard, then bubble
    idle(); resultsrc_ex = 2'b01; rd_ex = 5'd7; rs2_id = 5'd7;
    push(32'd1); push(32'd1); push(32'd1);
    #1; chk("lw_stall_if", 32'(stall_if)); chk("lw_stall_id", 32'(stall_id)); chk("lw_flush_ex", 32'(flush_ex));
    step();
    resultsrc_ex = 2'b00; rd_ex = 5'd0; push(32'd0);
    #1; chk("lw_bubble_no_stall", 32'(stall_id));
    step();
    cnt_clr = 1'b1; step(); cnt_clr = 1'b0;
    push(32'd0); chk("cnt_cleared", 32'(stall_cnt));

    // long op to x9, ID waits on rs1=9 for 12 cycles
    long_issue_ex = 1'b1; rd_ex = 5'd9; push(32'd0);
    #1; chk("issue9_no_stall", 32'(stall_id));
    step();
    long_issue_ex = 1'b0; rd_ex = 5'd0; rs1_id = 5'd9;
    push(32'h200); chk("busy9_set", busy);
    for (int i = 0; i < 12; i++) begin
      long_done = (i == 11); done_rd = 5'd9;
      push(32'd1);
      #1; chk("raw9_stall_id", 32'(stall_id));
      step();
    end
    long_done = 1'b0;
    push(32'd0); push(32'd0); push(32'd12); push(32'd0);
    #1;
    chk("raw9_released", 32'(stall_id)); chk("busy9_cleared", busy);
    chk("stall_cnt_12", 32'(stall_cnt)); chk("outstanding_0", 32'(outstanding));

    // outstanding cap with MAX_OUTSTANDING=2
    idle(); long_issue_ex = 1'b1; rd_ex = 5'd3; long_id = 1'b1; rd_id = 5'd10;
    push(32'd0); #1; chk("cap_first_free", 32'(stall_id));
    step();
    rd_ex = 5'd4; push(32'd1); push(32'd1); push(32'h8);
    #1; chk("cap_stall_pending", 32'(stall_id)); chk("outstanding_1", 32'(outstanding)); chk("busy3", busy);
    step();
    long_issue_ex = 1'b0; rd_ex = 5'd0; push(32'd2); push(32'd1); push(32'h18);
    #1; chk("outstanding_2", 32'(outstanding)); chk("cap_stall_full", 32'(stall_id)); chk("busy3_4", busy);
    step();
    long_id = 1'b0; long_done = 1'b1; done_rd = 5'd3; long_issue_ex = 1'b1; rd_ex = 5'd5;
    push(32'd1); push(32'd1);
    #1; chk("full_ex_wait", 32'(stall_ex)); chk("full_flush_mem", 32'(flush_mem));
    step();
    done_rd = 5'd4; push(32'd1); push(32'd0);
    #1; chk("outstanding_after_done", 32'(outstanding)); chk("ex_released", 32'(stall_ex));
    step();
    done_rd = 5'd5; push(32'd1); push(32'h20);
    #1; chk("issue_done_same_cnt", 32'(outstanding)); chk("busy5_only", busy);
    step();
    long_issue_ex = 1'b0; rd_ex = 5'd0; push(32'd1); push(32'h20);
    #1; chk("set_wins_cnt", 32'(outstanding)); chk("set_wins_busy", busy);
    step();
    idle(); push(32'd0); push(32'd0);
    #1; chk("drained_cnt", 32'(outstanding)); chk("drained_busy", busy);

    // error on done underflow, sticky, cleared only by reset
    long_done = 1'b1; done_rd = 5'd2; push(32'd0);
    #1; chk("err_before", 32'(error));
    step();
    idle(); push(32'd1); push(32'd0);
    chk("err_set", 32'(error)); chk("err_cnt_unchanged", 32'(outstanding));
    step(); push(32'd1); chk("err_sticky", 32'(error));
    long_issue_ex = 1'b1; rd_ex = 5'd8; step();
    idle(); push(32'h100); chk("busy8_before_rst", busy);
    rst_n = 1'b0;
    push(32'd0); push(32'd0); push(32'd0); push(32'd0);
    #1;
    chk("midrst_busy", busy); chk("midrst_outstanding", 32'(outstanding));
    chk("midrst_error", 32'(error)); chk("midrst_cnt", 32'(stall_cnt));
    rst_n = 1'b1;
    step();

    // redirect with dcache stall, counter saturation and clear priority
    pcsrc_ex = 1'b1; dcache_stall = 1'b1;
    push(32'd1); push(32'd1); push(32'd1); push(32'd1); push(32'd0);
    #1;
    chk("redir_flush_id", 32'(flush_id)); chk("redir_flush_ex", 32'(flush_ex));
    chk("dc_stall_ex", 32'(stall_ex)); chk("dc_stall_mem", 32'(stall_mem)); chk("stall_wb_0", 32'(stall_wb));
    pcsrc_ex = 1'b0;
    for (int i = 0; i < 20; i++) step();
    push(32'd15); chk("cnt_saturated", 32'(stall_cnt));
    cnt_clr = 1'b1; step(); cnt_clr = 1'b0;
    push(32'd0); chk("clr_over_incr", 32'(stall_cnt));

    if (exp_q.size() != 0) begin
      tests_run++;
      tests_failed++;
      $error("FAIL leftover_expected: observed %0d queued expected 0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL timeout: bench did not finish within 20000 time units");
    $fatal(1, "timeout");
  end

endmodule
